// File: rtl/atm_terminal_frontend_if.sv
// atm_terminal_frontend_if: card, keypad and core command/response signals of the ATM terminal front end.
interface atm_terminal_frontend_if;
  logic       card_in;
  logic [9:0] card_number;
  logic [10:0] card_expiry;
  logic       key_valid;
  logic [3:0] key_code;
  logic       atm_ready;
  logic       atm_declined;
  logic [9:0] credit_number;
  logic [10:0] expiration_date;
  logic [9:0] password;
  logic [9:0] new_password;
  logic [9:0] destination;
  logic [9:0] withdraw;
  logic [2:0] operation;
  logic       cmd_valid;
  logic       exit;
  logic       busy;
  logic       last_declined;
  modport master (
    input  card_in, card_number, card_expiry, key_valid, key_code, atm_ready, atm_declined,
    output credit_number, expiration_date, password, new_password, destination, withdraw,
    output operation, cmd_valid, exit, busy, last_declined
  );
  modport slave (
    output card_in, card_number, card_expiry, key_valid, key_code, atm_ready, atm_declined,
    input  credit_number, expiration_date, password, new_password, destination, withdraw,
    input  operation, cmd_valid, exit, busy, last_declined
  );
endinterface

// File: rtl/atm_terminal_frontend.sv
// atm_terminal_frontend: card/keypad session front end issuing one strobed command at a time to the ATM core.
// Define ATM_FRONTEND_TIMEOUT_EN to add the inactivity timeout that forces an eject.
module atm_terminal_frontend #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_DECLINES = 3,
  parameter int CNT_W = 10
) (
  input logic clock,
  input logic reset,
  atm_terminal_frontend_if.master bus
);
  localparam int DW = $clog2(MAX_DECLINES + 1);
  typedef enum logic [2:0] {IDLE, PIN, MENU, ARG1, ARG2, ISSUE, WAIT, EJECT} state_t;
  state_t state;
  logic [9:0] acc;
  logic [DW-1:0] dec_cnt;
  logic [13:0] acc_mul;
  logic [9:0] acc_sat;
  logic is_digit, is_enter, is_cancel, is_clear, entry, expired;
  if (2 ** CNT_W < TIMEOUT_CYCLES) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end
  assign acc_mul = 14'(acc) * 14'd10 + 14'(bus.key_code);
  assign acc_sat = acc_mul > 14'd1023 ? 10'd1023 : acc_mul[9:0];
  assign is_digit = bus.key_valid && bus.key_code < 4'd10;
  assign is_enter = bus.key_valid && bus.key_code == 4'd10;
  assign is_cancel = bus.key_valid && bus.key_code == 4'd11;
  assign is_clear = bus.key_valid && bus.key_code == 4'd12;
  assign entry = state == PIN || state == ARG1 || state == ARG2;
`ifdef ATM_FRONTEND_TIMEOUT_EN
  logic [CNT_W-1:0] timer;
  logic counting;
  assign counting = entry || state == MENU || state == WAIT;
  assign expired = counting && timer == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  assign expired = 1'b0;
`endif
  // Every state transition goes through here so the registered flags always match the new state.
  task automatic go(input state_t s);
    state <= s;
    bus.exit <= s == IDLE || s == EJECT;
    bus.busy <= s != IDLE;
    bus.cmd_valid <= s == ISSUE;
`ifdef ATM_FRONTEND_TIMEOUT_EN
    timer <= '0;
`endif
  endtask
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      dec_cnt <= '0;
      bus.credit_number <= '0;
      bus.expiration_date <= '0;
      bus.password <= '0;
      bus.new_password <= '0;
      bus.destination <= '0;
      bus.withdraw <= '0;
      bus.operation <= '0;
      bus.cmd_valid <= 1'b0;
      bus.exit <= 1'b1;
      bus.busy <= 1'b0;
      bus.last_declined <= 1'b0;
`ifdef ATM_FRONTEND_TIMEOUT_EN
      timer <= '0;
`endif
    end else begin
`ifdef ATM_FRONTEND_TIMEOUT_EN
      if (bus.key_valid || bus.atm_ready) timer <= '0;
      else if (counting) timer <= timer + 1'b1;
`endif
      if (entry && is_digit) acc <= acc_sat;
      else if (entry && is_clear) acc <= '0;
      case (state)
        IDLE: if (bus.card_in) begin
          bus.credit_number <= bus.card_number;
          bus.expiration_date <= bus.card_expiry;
          go(PIN);
        end
        PIN: if (expired || is_cancel) go(EJECT);
        else if (is_enter) begin
          bus.password <= acc;
          acc <= '0;
          go(MENU);
        end
        MENU: if (expired || is_cancel) go(EJECT);
        else if (is_digit && bus.key_code >= 4'd1 && bus.key_code <= 4'd6) begin
          bus.operation <= bus.key_code[2:0];
          go(bus.key_code == 4'd2 || bus.key_code == 4'd3 || bus.key_code == 4'd5 ? ARG1 : ISSUE);
        end
        ARG1, ARG2: if (expired) go(EJECT);
        else if (is_cancel) begin
          bus.operation <= '0;
          acc <= '0;
          go(MENU);
        end else if (is_enter) begin
          if (state == ARG2 || bus.operation == 3'd2) bus.withdraw <= acc;
          else if (bus.operation == 3'd3) bus.destination <= acc;
          else bus.new_password <= acc;
          acc <= '0;
          go(state == ARG1 && bus.operation == 3'd3 ? ARG2 : ISSUE);
        end
        ISSUE: go(WAIT);
        WAIT: if (bus.atm_ready) begin
          bus.last_declined <= bus.atm_declined;
          if (!bus.atm_declined) begin
            dec_cnt <= '0;
            if (bus.operation == 3'd5) bus.password <= bus.new_password;
            bus.operation <= '0;
            go(MENU);
          end else if (dec_cnt == DW'(MAX_DECLINES - 1)) go(EJECT);
          else begin
            dec_cnt <= dec_cnt + 1'b1;
            bus.operation <= '0;
            go(MENU);
          end
        end else if (expired) begin
          bus.last_declined <= 1'b1;
          go(EJECT);
        end
        EJECT: begin
          acc <= '0;
          dec_cnt <= '0;
          bus.credit_number <= '0;
          bus.expiration_date <= '0;
          bus.password <= '0;
          bus.new_password <= '0;
          bus.destination <= '0;
          bus.withdraw <= '0;
          bus.operation <= '0;
          go(IDLE);
        end
        default: go(IDLE);
      endcase
    end
  end
endmodule

// File: doc/atm_terminal_frontend.md
Name: atm_terminal_frontend

Overview:
Customer-side initiator for the ATM core's command interface. It captures card insertion, keypad PIN/menu/amount entry, and assembles the core's request fields (credit_number, expiration_date, password, new_password, destination, withdraw, operation, exit). It issues one strobed command at a time, waits for the core's accept/decline response, and manages session lifetime through cancel, decline limit and inactivity timeout.

Parameters:
TIMEOUT_CYCLES, 1000, inactivity cycles before forced eject
MAX_DECLINES, 3, consecutive declined commands before forced eject
CNT_W, 10, timeout counter width (2**CNT_W >= TIMEOUT_CYCLES)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
card_in  in  1  one-cycle pulse: card inserted
card_number  in  10  card number, valid with card_in
card_expiry  in  11  card expiry year, valid with card_in
key_valid  in  1  one-cycle keypad strobe
key_code  in  4  0-9 digit, 10 ENTER, 11 CANCEL, 12 CLEAR, 13-15 ignored
atm_ready  in  1  one-cycle pulse: core finished current command
atm_declined  in  1  core decline flag, sampled only with atm_ready
credit_number  out  10  latched card number
expiration_date  out  11  latched expiry
password  out  10  entered PIN
new_password  out  10  PIN for change-password
destination  out  10  transfer destination
withdraw  out  10  amount for withdraw/transfer
operation  out  3  1 balance, 2 withdraw, 3 transfer, 4 report, 5 change PIN, 6 unban
cmd_valid  out  1  one-cycle command strobe to core
exit  out  1  high = no session, core must not operate
busy  out  1  high when state != IDLE
last_declined  out  1  result of last completed command

Behaviour:
- Reset (async, immediate): state IDLE; all data outputs 0; operation 0; cmd_valid 0; exit 1; busy 0; last_declined 0; accumulator, decline count and timer 0. Reset during WAIT drops cmd_valid and the pending command; no later atm_ready is honoured.
- Accumulator acc[9:0]: on a digit key, acc <= min(acc*10+digit, 1023), computed at 14 bits then saturated. CLEAR sets acc to 0. ENTER commits acc to the target field and then clears acc.
- IDLE: exit=1. card_in latches card_number/expiry and goes to PIN with exit=0. card_in is ignored in every other state. Keys are ignored in IDLE.
- PIN: ENTER sets password=acc and goes to MENU. CANCEL goes to EJECT.
- MENU: digit d in 1..6 sets operation=d. Ops 1, 4, 6 go to ISSUE. Op 2 goes to ARG1 (withdraw). Op 3 goes to ARG1 (destination), then ARG2 (withdraw). Op 5 goes to ARG1 (new_password). Digits 0, 7-9, ENTER and CLEAR are ignored. CANCEL goes to EJECT.
- ARG1/ARG2: ENTER commits and moves to the next state (ARG2 or ISSUE). CANCEL sets operation=0 and returns to MENU without ejecting.
- ISSUE: cmd_valid=1 for exactly one cycle, then WAIT. All request fields are stable from the ISSUE cycle until atm_ready.
- WAIT: keys are ignored. On atm_ready, last_declined<=atm_declined.
  - Accepted: decline count=0. If op 5, password<=new_password.
  - Declined: decline count+1; reaching MAX_DECLINES goes to EJECT.
  - Otherwise return to MENU with operation=0. atm_ready outside WAIT is ignored.
- EJECT: one cycle with exit=1. All latched fields and the decline count clear to 0, then IDLE. last_declined is held.
- Latency: ENTER/menu key to cmd_valid is 1 cycle for ops 1/4/6 (key cycle -> ISSUE). atm_ready to MENU is 1 cycle.
- busy=1 in all states except IDLE.

Optional Feature:
ATM_FRONTEND_TIMEOUT_EN
- Defined:
  - The timer clears on key_valid, atm_ready or any state change, and increments otherwise in PIN/MENU/ARG1/ARG2/WAIT.
  - Reaching TIMEOUT_CYCLES-1 forces EJECT. A timeout in WAIT also sets last_declined=1.
  - atm_ready in the same cycle as expiry wins, and the timeout is discarded.
- Undefined: no timer logic. A session ends only via CANCEL, MAX_DECLINES or reset.

Test Plan:
1. card_in with number 500, expiry 2023; keys 5,0,0,ENTER,1 -> one cmd_valid pulse with credit_number=500, password=500, operation=1; atm_ready with declined=0 -> MENU, last_declined=0.
2. Menu 3, keys 1,0,0,0,ENTER,9,0,ENTER -> cmd_valid with destination=1000, withdraw=90, operation=3; keys 9,9,9,9,ENTER at amount -> withdraw saturates to 1023.
3. Menu 5, keys 1,ENTER, accepted -> password becomes 1. Repeat with declined=1 -> password unchanged, last_declined=1.
4. Three consecutive declined commands (MAX_DECLINES=3) -> EJECT: exit=1 for one cycle, all fields 0, IDLE; a fourth key is ignored.
5. CANCEL in ARG1 -> MENU, operation=0, no cmd_valid. CANCEL in MENU -> EJECT. card_in during MENU -> ignored, credit_number unchanged.
6. With ATM_FRONTEND_TIMEOUT_EN and TIMEOUT_CYCLES=20: idle in MENU for 20 cycles -> EJECT. In WAIT, with no atm_ready -> EJECT and last_declined=1. Assert reset during WAIT -> cmd_valid=0, exit=1 immediately.
